// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  // Quotient on divide-by-zero is all ones; replicated to WIDTH at use.
  localparam logic DIV0_FILL = 1'b1;

  // Ops 000..011 are the iterative ones; bit 2 marks HI/LO moves and no-ops.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between EX stage and the multiply/divide unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, cancel, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, cancel, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_iter_step.sv
// One combinational iteration: shift-add (multiply) or restoring
// shift-subtract (divide) on a 2*WIDTH accumulator.
//   multiply: acc = {partial_hi, remaining multiplier bits}, opnd = multiplicand
//   divide:   acc = {partial_rem, dividend/quotient bits},   opnd = divisor
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // Carry out of the add becomes the top bit after the right shift.
  assign sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
  // Trial subtract of the left-shifted remainder; diff[WIDTH] is the borrow.
  assign diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};

  // Pick the step; on borrow the remainder is restored by simply shifting.
  always_comb begin
    acc_next = '0;
    if (is_div) begin
      if (diff[WIDTH]) acc_next = {acc[2*WIDTH-2:0], 1'b0};
      else             acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply/divide with architectural HI/LO.
// Works on magnitudes for WIDTH cycles, then sign-corrects in one FIX cycle.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_div_unit_if.slave bus
);

  mdu_state_e         state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [WIDTH-1:0]   opnd;
  logic               is_div, neg_q, neg_r, div_zero;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic               accept_md, wr_hi, wr_lo, step_en, fix_en, last_iter;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: cancel wins in RUN/FIX, has no effect in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start && is_muldiv(bus.op)) state_nxt = ST_RUN;
      ST_RUN: begin
        if (bus.cancel)     state_nxt = ST_IDLE;
        else if (last_iter) state_nxt = ST_FIX;
      end
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM decode into datapath enables.
  always_comb begin
    accept_md = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    step_en   = 1'b0;
    fix_en    = 1'b0;
    case (state)
      ST_IDLE: if (bus.start) begin
        accept_md = is_muldiv(bus.op);
        wr_hi     = (bus.op == MDU_MTHI);
        wr_lo     = (bus.op == MDU_MTLO);
      end
      ST_RUN:  step_en = !bus.cancel;
      ST_FIX:  fix_en  = !bus.cancel;
      default: ;
    endcase
  end

  // Operand magnitudes; unsigned ops (op[0]=1) never negate.
  always_comb begin
    a_neg = !bus.op[0] && bus.a[WIDTH-1];
    b_neg = !bus.op[0] && bus.b[WIDTH-1];
    mag_a = a_neg ? -bus.a : bus.a;
    mag_b = b_neg ? -bus.b : bus.b;
  end

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_step)
  );

  // Sign correction of the finished magnitude result.
  always_comb begin
    prod   = neg_q ? -acc : acc;
    quo    = acc[WIDTH-1:0];
    rem    = acc[2*WIDTH-1:WIDTH];
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div) begin
      fix_hi = neg_r ? -rem : rem;
      fix_lo = div_zero ? {WIDTH{DIV0_FILL}} : (neg_q ? -quo : quo);
    end
  end

  // Accumulator, counter and sign flags. Both mul and div start from
  // {0, |a|} with |b| as the step operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      opnd     <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (accept_md) begin
      acc      <= {{WIDTH{1'b0}}, mag_a};
      opnd     <= mag_b;
      cnt      <= '0;
      is_div   <= bus.op[1];
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      div_zero <= bus.op[1] && (bus.b == '0);
    end else if (step_en) begin
      acc <= acc_step;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // HI/LO architectural registers and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= fix_en;
      if (fix_en) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end else begin
        if (wr_hi) hi_q <= bus.a;
        if (wr_lo) lo_q <= bus.a;
      end
    end
  end

  assign bus.busy = (state != ST_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised iterative multiply/divide unit that sits beside the combinational ALU in the EX stage of the pipeline. It owns the architectural HI/LO register pair and executes signed and unsigned multiply and divide over several cycles under a start/busy/done handshake. It also executes single-cycle HI/LO writes. The hazard unit stalls on `busy`; `cancel` is driven from the pipeline flush.

## Interface
- `WIDTH`, default 32: operand width and HI/LO width; must be even and ≥ 4.
- `CNT_W`, default $clog2(WIDTH)+1: iteration counter width; derived, not overridden.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only when `busy`=0.
- `op` in 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
- `a` in WIDTH: multiplicand / dividend / MTHI-MTLO data.
- `b` in WIDTH: multiplier / divisor.
- `cancel` in 1: abort the operation in flight.
- `busy` out 1: operation in progress; stall request.
- `done` out 1: one-cycle pulse when HI/LO take a multiply/divide result.
- `hi` out WIDTH: HI register, registered output.
- `lo` out WIDTH: LO register, registered output.

## Operation
- **Reset values:** `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- **States:** IDLE, RUN, FIX.
- **IDLE**, `start`=1, op MULT/MULTU/DIV/DIVU:
  - Latch operand magnitudes. Signed ops take the two's-complement absolute value.
  - Latch the result sign flags: product sign = a[W-1]^b[W-1]; remainder sign = a[W-1].
  - Clear the counter and go to RUN.
- **IDLE**, `start`=1, op MTHI/MTLO:
  - Write `a` into `hi` or `lo` at that edge.
  - Stay in IDLE; `busy` and `done` remain 0.
- **IDLE**, op 110/111: ignored.
- **RUN:** one iteration per cycle; after WIDTH iterations go to FIX.
  - Multiply: shift-add on a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
- **FIX:**
  - Apply sign correction: negate the product if the product sign flag is set. For divide, negate the quotient if a[W-1]^b[W-1] and negate the remainder if a[W-1].
  - Write `hi` and `lo`, then go to IDLE.
  - Multiply: `hi`=upper half, `lo`=lower half. Divide: `lo`=quotient, `hi`=remainder.
- **Divide by zero** (b=0), both DIV and DIVU: `lo`={WIDTH{1}}, `hi`=a. Normal latency; `done` still pulses.
- **DIV of MIN by −1:** `lo`=MIN, `hi`=0, with no special handling. This is the natural result of the magnitude algorithm.
- **`cancel`=1 in RUN or FIX:** return to IDLE at that edge. `hi`/`lo` are untouched and no `done` is issued. `cancel` in IDLE has no effect and overrides nothing.
- **`start` while `busy`=1:** ignored, including MTHI/MTLO. The pipeline must stall it.
- **Reset mid-operation:** immediate return to the reset values; the partial result is discarded.
- Operands and `op` need not be held stable after the accept edge.

## Timing
- Accept edge E0 (IDLE, `start`=1, mul/div op) → `busy`=1 from E0 until E(WIDTH+1).
- RUN occupies edges E1..E(WIDTH). FIX is edge E(WIDTH+1), where `hi`/`lo` update and `busy` falls.
- `done`=1 for exactly the cycle following E(WIDTH+1).
- Latency: WIDTH+1 cycles from accept to the result visible on `hi`/`lo`. A new `start` is accepted on the same cycle `done` is high.
- MTHI/MTLO: the value is visible on `hi`/`lo` the cycle after the accept edge.
- `busy` and `done` are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `mdu_pkg`: op encodings (`MDU_MULT`..`MDU_MTLO`), the state enum (IDLE/RUN/FIX), and the divide-by-zero fill constant.
- Sub-module `mdu_iter_step`: combinational single-iteration datapath, one shift-add or shift-subtract step selected by a mul/div flag. The parent holds the accumulator, counter, FSM and HI/LO.
- Target size: ~200 lines of RTL.

## Test plan
All cases use WIDTH=32.
- **MULT** a=0xFFFFFFFD (−3), b=7 → after 33 cycles `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `done` pulses once; `busy` is high for 33 cycles.
- **MULTU** a=b=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- **DIV** a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- **DIV corner cases:**
  - DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
  - DIVU a=100, b=0 → `lo`=0xFFFFFFFF, `hi`=0x64.
- **Handshake and cancel:**
  - MTHI 0x1234 → `hi`=0x1234 next cycle, `done`=0.
  - Start DIVU, then MTLO with `start` during `busy` → MTLO is ignored.
  - Start DIVU, then assert `cancel` at cycle 10 → no `done`; `hi`/`lo` unchanged; `busy`=0 next cycle.
- **Reset:** assert `rst_n`=0 asynchronously at cycle 15 of a MULT → `hi`/`lo`/`busy`/`done` read 0 immediately. After release, a new MULT completes correctly.
